// File: rtl/_cnt_ud_ld_pkg.sv
// Shared constants for the loadable up/down counter.
package _cnt_ud_ld_pkg;

   // Default counter width
   localparam int unsigned CNT_W_DEF = 4;

   // Direction encodings for dn
   localparam logic CNT_UP = 1'b0;
   localparam logic CNT_DN = 1'b1;

endpackage : _cnt_ud_ld_pkg

// File: rtl/_cnt_ud_ld_if.sv
// Control/status bundle of the loadable up/down counter.
interface _cnt_ud_ld_if
   import _cnt_ud_ld_pkg::*;
#(
   parameter int unsigned W = CNT_W_DEF
);

   logic         clr;
   logic         ld;
   logic         en;
   logic         dn;
   logic [W-1:0] d_in;
   logic [W-1:0] q;
   logic         tc;
   logic         ovf;

   // Controller side: drives commands, observes count
   modport master (
      output clr, ld, en, dn, d_in,
      input  q, tc, ovf
   );

   // Counter side
   modport slave (
      input  clr, ld, en, dn, d_in,
      output q, tc, ovf
   );

endinterface : _cnt_ud_ld_if

// File: rtl/_cnt_ud_ld_dff_r.sv
// D flip-flop with asynchronous active-low reset to 0.
module _dff_r (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   // State bit, cleared immediately on reset assertion
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) q <= 1'b0;
      else          q <= d;
   end

endmodule : _dff_r

// File: rtl/_cnt_ud_ld_gates.sv
// Gate primitives used by the counter next-state logic.

// Inverter
module _inv (
   input  logic a,
   output logic y
);
   assign y = ~a;
endmodule : _inv

// Two-input AND
module _and2 (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a & b;
endmodule : _and2

// Two-input OR
module _or2 (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a | b;
endmodule : _or2

// Two-input XOR
module _xor2 (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a ^ b;
endmodule : _xor2

// File: rtl/_cnt_ud_ld.sv
// Loadable up/down counter with sync clear, enable, terminal count and
// sticky overflow. Next state is built purely from gate primitives.
// Build option: define CNT_SAT_EN for saturating (non-wrapping) count.
module _cnt_ud_ld
   import _cnt_ud_ld_pkg::*;
#(
   parameter int unsigned W = CNT_W_DEF
) (
   input  logic           clk,
   input  logic           reset_n,
   _cnt_ud_ld_if.slave    bus
);

   logic [W-1:0] q_r;      // count state
   logic [W-1:0] p;        // q_i xor dn: bit "propagates" the carry/borrow
   logic [W:0]   toggle;   // toggle[i]: all lower bits propagate
   logic [W-1:0] tg;       // gated toggle per bit
   logic [W-1:0] cnt;      // counted value
   logic [W-1:0] ld_t;     // load term
   logic [W-1:0] cnt_t;    // count/hold term
   logic [W-1:0] mux;      // load vs count select
   logic [W-1:0] nxt;      // next state after clear
   logic         clr_n;
   logic         ld_n;
   logic         tc;
   logic         en_cnt;
   logic         en_tc;
   logic         wrap;
   logic         ovf_r;
   logic         ovf_set;
   logic         ovf_nxt;

   _inv u_clr_inv (.a(bus.clr), .y(clr_n));
   _inv u_ld_inv  (.a(bus.ld),  .y(ld_n));

   // Ripple chain seed: bit 0 always toggles when counting
   assign toggle[0] = 1'b1;

   // Terminal count is the top term of the toggle chain
   assign tc = toggle[W];

`ifdef CNT_SAT_EN
   // Suppress the toggle at the terminal value so q saturates
   logic tc_n;
   _inv  u_tc_inv (.a(tc), .y(tc_n));
   _and2 u_en_sat (.a(bus.en), .b(tc_n), .y(en_cnt));
`else
   assign en_cnt = bus.en;
`endif

   // Per-bit ripple incrementer/decrementer, load mux, clear and state bit
   for (genvar i = 0; i < W; i++) begin : g_bit
      _xor2 u_prop (.a(q_r[i]),      .b(bus.dn),    .y(p[i]));
      _and2 u_chn  (.a(toggle[i]),   .b(p[i]),      .y(toggle[i+1]));
      _and2 u_tgen (.a(toggle[i]),   .b(en_cnt),    .y(tg[i]));
      _xor2 u_cnt  (.a(q_r[i]),      .b(tg[i]),     .y(cnt[i]));
      _and2 u_ldt  (.a(bus.ld),      .b(bus.d_in[i]), .y(ld_t[i]));
      _and2 u_cntt (.a(ld_n),        .b(cnt[i]),    .y(cnt_t[i]));
      _or2  u_mux  (.a(ld_t[i]),     .b(cnt_t[i]),  .y(mux[i]));
      _and2 u_clr  (.a(clr_n),       .b(mux[i]),    .y(nxt[i]));
      _dff_r u_ff  (.clk(clk), .reset_n(reset_n), .d(nxt[i]), .q(q_r[i]));
   end : g_bit

   // Wrap event: counting at terminal count with no load (clear masks below)
   _and2 u_en_tc (.a(bus.en), .b(tc),   .y(en_tc));
   _and2 u_wrap  (.a(en_tc),  .b(ld_n), .y(wrap));

   // Sticky overflow: set on wrap, held until clear or reset
   _or2  u_ovf_or  (.a(ovf_r), .b(wrap),    .y(ovf_set));
   _and2 u_ovf_clr (.a(clr_n), .b(ovf_set), .y(ovf_nxt));
   _dff_r u_ovf_ff (.clk(clk), .reset_n(reset_n), .d(ovf_nxt), .q(ovf_r));

   assign bus.q   = q_r;
   assign bus.tc  = tc;
   assign bus.ovf = ovf_r;

endmodule : _cnt_ud_ld

// File: tb/tb__cnt_ud_ld.sv
// Directed self-checking bench for the loadable up/down counter.
module tb__cnt_ud_ld;
   import _cnt_ud_ld_pkg::*;

   localparam int unsigned W = 4;

   logic clk;
   logic reset_n;
   int   checks;
   int   failures;

   _cnt_ud_ld_if #(.W(W)) bus ();

   _cnt_ud_ld #(.W(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Advance one active edge, then settle before checking
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input int eq, input int etc, input int eovf);
      chk({tag, ".q"},   32'(bus.q),   32'(eq));
      chk({tag, ".tc"},  32'(bus.tc),  32'(etc));
      chk({tag, ".ovf"}, 32'(bus.ovf), 32'(eovf));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int eq;
      checks   = 0;
      failures = 0;
      reset_n  = 1'b0;
      bus.clr  = 1'b0;
      bus.ld   = 1'b0;
      bus.en   = 1'b0;
      bus.dn   = CNT_UP;
      bus.d_in = '0;

      // Reset state; tc depends on direction
      #3;
      chk_state("rst_up", 0, 0, 0);
      bus.dn = CNT_DN;
      #1;
      chk("rst_dn.tc", 32'(bus.tc), 32'd1);
      bus.dn = CNT_UP;
      #8;
      reset_n = 1'b1;              // released at t=12, between edges

      // Up count 17 cycles from 0
      bus.en = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         step();
`ifdef CNT_SAT_EN
         eq = (k < 15) ? k : 15;
`else
         eq = (k < 16) ? k : k - 16;
`endif
         chk_state($sformatf("up%0d", k), eq, (eq == 15) ? 1 : 0, (k >= 16) ? 1 : 0);
      end

      // Load 9: ovf must survive the load
      bus.en   = 1'b0;
      bus.ld   = 1'b1;
      bus.d_in = 4'd9;
      step();
      chk_state("ld9", 9, 0, 1);
      bus.ld = 1'b0;

      // Async reset mid-cycle clears q and ovf before the next edge
      #2;
      reset_n = 1'b0;
      #1;
      chk_state("async_rst", 0, 0, 0);
      #2;
      reset_n = 1'b1;

      // Down count: load 2, then three decrements
      bus.ld   = 1'b1;
      bus.d_in = 4'd2;
      step();
      chk_state("dn_ld", 2, 0, 0);
      bus.ld = 1'b0;
      bus.en = 1'b1;
      bus.dn = CNT_DN;
      step();
      chk_state("dn1", 1, 0, 0);
      step();
      chk_state("dn0", 0, 1, 0);
      step();
`ifdef CNT_SAT_EN
      chk_state("dn_wrap", 0, 1, 1);
`else
      chk_state("dn_wrap", 15, 0, 1);
`endif

      // Priority: clear beats load and enable
      bus.clr  = 1'b1;
      bus.ld   = 1'b1;
      bus.en   = 1'b1;
      bus.dn   = CNT_UP;
      bus.d_in = 4'd7;
      step();
      chk_state("prio_clr", 0, 0, 0);
      bus.clr = 1'b0;
      step();
      chk_state("prio_ld", 7, 0, 0);

      // Load at terminal count with enable is not a wrap event
      bus.d_in = 4'd15;
      step();
      chk_state("ld15", 15, 1, 0);
      bus.d_in = 4'd3;
      step();
      chk_state("ld_at_tc", 3, 0, 0);

      // Hold then direction flip
      bus.en   = 1'b0;
      bus.d_in = 4'd5;
      step();
      chk_state("ld5", 5, 0, 0);
      bus.ld = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("hold%0d.q", k), 32'(bus.q), 32'd5);
      end
      bus.en = 1'b1;
      bus.dn = CNT_UP;
      step();
      chk("flip0.q", 32'(bus.q), 32'd6);
      bus.dn = CNT_DN;
      step();
      chk("flip1.q", 32'(bus.q), 32'd5);
      bus.dn = CNT_UP;
      step();
      chk("flip2.q", 32'(bus.q), 32'd6);
      bus.dn = CNT_DN;
      step();
      chk_state("flip3", 5, 0, 0);

      // Carry ripple across all bits: 7 -> 8 -> 7
      bus.en   = 1'b0;
      bus.ld   = 1'b1;
      bus.d_in = 4'd7;
      step();
      bus.ld = 1'b0;
      bus.en = 1'b1;
      bus.dn = CNT_UP;
      step();
      chk("ripple_up.q", 32'(bus.q), 32'd8);
      bus.dn = CNT_DN;
      step();
      chk("ripple_dn.q", 32'(bus.q), 32'd7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb__cnt_ud_ld
